// File: rtl/reg_bank_pkg.sv
// Shared constants for the register bank: register indices, constant-generator
// values, PC lower limit and FSM state encoding.
package reg_bank_pkg;

  localparam int PC_IDX = 0;
  localparam int SP_IDX = 1;
  localparam int SR_IDX = 2;
  localparam int CG_IDX = 3;

  localparam logic [15:0] PC_MIN   = 16'h0200;
  localparam logic [15:0] CG_ONE   = 16'h0001;
  localparam logic [15:0] CG_TWO   = 16'h0002;
  localparam logic [15:0] CG_FOUR  = 16'h0004;
  localparam logic [15:0] CG_EIGHT = 16'h0008;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

endpackage

// File: rtl/reg_bank_cg.sv
// Constant generator: overrides the source read for SR (as != 0) and CG
// register indices with fixed constants.
module reg_bank_cg
  import reg_bank_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic [1:0]        as,
  input  logic [ADDR_W-1:0] sa,
  input  logic [DATA_W-1:0] stored,
  output logic [DATA_W-1:0] sout
);

  always_comb begin
    sout = stored;
    if (sa == ADDR_W'(CG_IDX)) begin
      case (as)
        2'b00:   sout = '0;
        2'b01:   sout = DATA_W'(CG_ONE);
        2'b10:   sout = DATA_W'(CG_TWO);
        default: sout = '1;
      endcase
    end else if (sa == ADDR_W'(SR_IDX)) begin
      case (as)
        2'b01:   sout = '0;
        2'b10:   sout = DATA_W'(CG_FOUR);
        2'b11:   sout = DATA_W'(CG_EIGHT);
        default: sout = stored;
      endcase
    end
  end

endmodule

// File: rtl/reg_bank.sv
// Register bank with sequenced clear after reset, two write ports plus PC/SR
// update ports. Optional same-cycle port-A read bypass under REG_BANK_BYPASS_EN.
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] rst_vec,
  input  logic [ADDR_W-1:0] sa,
  input  logic [ADDR_W-1:0] da,
  input  logic [1:0]        as,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] wa_addr,
  input  logic [DATA_W-1:0] wa_data,
  input  logic              bw_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              pc_we,
  input  logic [DATA_W-1:0] pc_in,
  input  logic              sr_we,
  input  logic [DATA_W-1:0] sr_in,
  output logic [DATA_W-1:0] sout,
  output logic [DATA_W-1:0] dout,
  output logic [DATA_W-1:0] pc_out,
  output logic [DATA_W-1:0] sp_out,
  output logic [DATA_W-1:0] sr_out,
  output logic              ready
);

  localparam int NREG = 2 ** ADDR_W;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clr_idx;
  logic [DATA_W-1:0] regs   [NREG];
  logic [DATA_W-1:0] reg_wd [NREG];
  logic [NREG-1:0]   reg_we;
  logic [DATA_W-1:0] a_val;
  logic [DATA_W-1:0] s_stored, d_stored;

  assign ready = (state == ST_RUN);
  assign a_val = bw_a ? {{(DATA_W-8){1'b0}}, wa_data[7:0]} : wa_data;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RESET: state_nxt = ST_CLEAR;
      ST_CLEAR: if (clr_idx == ADDR_W'(NREG-1)) state_nxt = ST_RUN;
      default:  state_nxt = state;
    endcase
  end

  // Per-register write select: port A over port B over the dedicated PC/SR ports.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      reg_we[i] = 1'b0;
      reg_wd[i] = '0;
      if (state == ST_CLEAR) begin
        if (clr_idx == ADDR_W'(i)) begin
          reg_we[i] = 1'b1;
          reg_wd[i] = (i == PC_IDX) ? rst_vec : '0;
        end
      end else if (state == ST_RUN && i != CG_IDX) begin
        if (we_a && wa_addr == ADDR_W'(i)) begin
          reg_we[i] = 1'b1;
          reg_wd[i] = a_val;
        end else if (we_b && wb_addr == ADDR_W'(i)) begin
          reg_we[i] = 1'b1;
          reg_wd[i] = wb_data;
        end else if (i == PC_IDX && pc_we) begin
          reg_we[i] = 1'b1;
          reg_wd[i] = pc_in;
        end else if (i == SR_IDX && sr_we) begin
          reg_we[i] = 1'b1;
          reg_wd[i] = sr_in;
        end
        if (i == PC_IDX && reg_wd[i] < DATA_W'(PC_MIN)) reg_wd[i] = rst_vec;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ST_RESET;
      clr_idx          <= '0;
      regs[PC_IDX]     <= rst_vec;
      regs[SR_IDX]     <= '0;
    end else begin
      state   <= state_nxt;
      clr_idx <= (state == ST_CLEAR) ? clr_idx + 1'b1 : '0;
      for (int i = 0; i < NREG; i++) begin
        if (reg_we[i]) regs[i] <= reg_wd[i];
      end
    end
  end

`ifdef REG_BANK_BYPASS_EN
  assign s_stored = (we_a && ready && sa == wa_addr) ? a_val : regs[sa];
  assign d_stored = (we_a && ready && da == wa_addr) ? a_val : regs[da];
`else
  assign s_stored = regs[sa];
  assign d_stored = regs[da];
`endif

  reg_bank_cg #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_cg (
    .as     (as),
    .sa     (sa),
    .stored (s_stored),
    .sout   (sout)
  );

  assign dout   = d_stored;
  assign pc_out = regs[PC_IDX];
  assign sp_out = regs[SP_IDX];
  assign sr_out = regs[SR_IDX];

endmodule

// File: tb/tb_reg_bank.sv
// Scoreboard bench for reg_bank: stimulus pushes expected read values from an
// array model; a negedge monitor pops and compares.
module tb_reg_bank;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int NR = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] rst_vec;
  logic [AW-1:0] sa, da;
  logic [1:0]    as_s;
  logic          we_a, bw_a, we_b, pc_we, sr_we;
  logic [AW-1:0] wa_addr, wb_addr;
  logic [DW-1:0] wa_data, wb_data, pc_in, sr_in;
  logic [DW-1:0] sout, dout, pc_out, sp_out, sr_out;
  logic          ready;

  always #5 clk = ~clk;

  reg_bank #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .rst_vec(rst_vec), .sa(sa), .da(da), .as(as_s),
    .we_a(we_a), .wa_addr(wa_addr), .wa_data(wa_data), .bw_a(bw_a),
    .we_b(we_b), .wb_addr(wb_addr), .wb_data(wb_data),
    .pc_we(pc_we), .pc_in(pc_in), .sr_we(sr_we), .sr_in(sr_in),
    .sout(sout), .dout(dout), .pc_out(pc_out), .sp_out(sp_out),
    .sr_out(sr_out), .ready(ready)
  );

  typedef struct {
    logic          rst;
    logic [DW-1:0] rst_vec;
    logic [AW-1:0] sa, da;
    logic [1:0]    as_m;
    logic          we_a;
    logic [AW-1:0] wa_addr;
    logic [DW-1:0] wa_data;
    logic          bw_a;
    logic          we_b;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          pc_we;
    logic [DW-1:0] pc_in;
    logic          sr_we;
    logic [DW-1:0] sr_in;
  } stim_t;

  typedef struct {
    logic [DW-1:0] sout, dout, pc, sp, sr;
    logic          rdy;
    bit            full;
  } exp_t;

  exp_t          expq[$];
  logic [DW-1:0] m [NR];
  int            n = 0;       // cycles since reset release (ready once > NR)
  bit            known = 0;   // every model register has a defined value
  bit            started = 0;
  int            errors = 0;
  int            checks = 0;
  logic [DW-1:0] cg3 [4] = '{16'h0000, 16'h0001, 16'h0002, 16'hFFFF};
  logic [DW-1:0] cg2 [4] = '{16'h0000, 16'h0000, 16'h0004, 16'h0008};

  function automatic logic [DW-1:0] aval(stim_t s);
    return s.bw_a ? {8'h00, s.wa_data[7:0]} : s.wa_data;
  endfunction

  function automatic logic [DW-1:0] stored(stim_t s, logic [AW-1:0] idx);
`ifdef REG_BANK_BYPASS_EN
    if (s.we_a && n > NR && idx == s.wa_addr) return aval(s);
`endif
    return m[idx];
  endfunction

  function automatic logic [DW-1:0] src(stim_t s);
    if (s.sa == 4'd3) return cg3[s.as_m];
    if (s.sa == 4'd2 && s.as_m != 2'b00) return cg2[s.as_m];
    return stored(s, s.sa);
  endfunction

  task automatic model_edge(stim_t s);
    logic [DW-1:0] nm [NR];
    bit pcw;
    if (s.rst) begin
      n = 0; m[0] = s.rst_vec; m[2] = '0; started = 1;
    end else if (n == 0) begin
      n = 1;
    end else if (n <= NR) begin
      m[n-1] = (n == 1) ? s.rst_vec : '0;
      if (n == NR) known = 1;
      n++;
    end else begin
      nm = m; pcw = 0;
      // Lowest priority applied first so higher-priority ports overwrite.
      if (s.sr_we) nm[2] = s.sr_in;
      if (s.pc_we) begin nm[0] = s.pc_in; pcw = 1; end
      if (s.we_b) begin nm[s.wb_addr] = s.wb_data; if (s.wb_addr == 0) pcw = 1; end
      if (s.we_a) begin nm[s.wa_addr] = aval(s); if (s.wa_addr == 0) pcw = 1; end
      nm[3] = m[3];
      if (pcw && nm[0] < 16'h0200) nm[0] = s.rst_vec;
      m = nm;
    end
  endtask

  task automatic apply(stim_t s);
    exp_t e;
    rst = s.rst; rst_vec = s.rst_vec; sa = s.sa; da = s.da; as_s = s.as_m;
    we_a = s.we_a; wa_addr = s.wa_addr; wa_data = s.wa_data; bw_a = s.bw_a;
    we_b = s.we_b; wb_addr = s.wb_addr; wb_data = s.wb_data;
    pc_we = s.pc_we; pc_in = s.pc_in; sr_we = s.sr_we; sr_in = s.sr_in;
    if (started) begin
      e.rdy = (n > NR); e.pc = m[0]; e.sp = m[1]; e.sr = m[2];
      e.sout = src(s); e.dout = stored(s, s.da); e.full = known;
      expq.push_back(e);
    end
    @(posedge clk);
    model_edge(s);
    #1;
  endtask

  task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      chk("ready", {15'd0, ready}, {15'd0, e.rdy});
      chk("pc_out", pc_out, e.pc);
      chk("sr_out", sr_out, e.sr);
      if (e.full) begin
        chk("sp_out", sp_out, e.sp);
        chk("sout", sout, e.sout);
        chk("dout", dout, e.dout);
      end
    end
  end

  function automatic stim_t idle(logic r, logic [DW-1:0] rv);
    stim_t s;
    s = '{default: '0};
    s.rst = r; s.rst_vec = rv;
    s.sa = 4'($urandom_range(0, 15)); s.da = 4'($urandom_range(0, 15));
    s.as_m = 2'($urandom_range(0, 3));
    return s;
  endfunction

  function automatic stim_t rnd(logic [DW-1:0] rv);
    stim_t s;
    s = idle(1'b0, rv);
    s.we_a = ($urandom_range(0, 1) == 1);
    s.wa_addr = 4'($urandom_range(0, 15));
    s.wa_data = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 16'h03FF)) : 16'($urandom);
    s.bw_a = ($urandom_range(0, 3) == 0);
    s.we_b = ($urandom_range(0, 1) == 1);
    s.wb_addr = 4'($urandom_range(0, 15));
    s.wb_data = 16'($urandom);
    s.pc_we = ($urandom_range(0, 3) == 0);
    s.pc_in = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 16'h03FF)) : 16'($urandom);
    s.sr_we = ($urandom_range(0, 3) == 0);
    s.sr_in = 16'($urandom);
    return s;
  endfunction

  initial begin
    stim_t s;
    logic [DW-1:0] rv;
    rv = 16'hF800;
    // Reset for two cycles, then full clear with idle reads.
    repeat (2) apply(idle(1'b1, rv));
    repeat (NR + 4) apply(idle(1'b0, rv));
    repeat (40) apply(rnd(rv));
    // Reset mid-clear (index 5); writes during clear must be ignored.
    apply(idle(1'b1, rv));
    repeat (6) apply(rnd(rv));
    apply(idle(1'b1, rv));
    repeat (NR + 3) apply(rnd(rv));
    // Same-register port collision, byte write.
    s = idle(1'b0, rv); s.we_a = 1; s.wa_addr = 4; s.wa_data = 16'h1234;
    s.we_b = 1; s.wb_addr = 4; s.wb_data = 16'h5678; apply(s);
    s = idle(1'b0, rv); s.we_a = 1; s.wa_addr = 5; s.wa_data = 16'hABCD; s.bw_a = 1; s.da = 4; apply(s);
    s = idle(1'b0, rv); s.da = 5; apply(s);
    // Constant generator and R3 write discard.
    s = idle(1'b0, rv); s.sa = 3; s.as_m = 2'b11; apply(s);
    s = idle(1'b0, rv); s.sa = 2; s.as_m = 2'b10; apply(s);
    s = idle(1'b0, rv); s.we_a = 1; s.wa_addr = 3; s.wa_data = 16'h1111; apply(s);
    for (int i = 0; i < 4; i++) begin
      s = idle(1'b0, rv); s.sa = 3; s.da = 3; s.as_m = 2'(i); apply(s);
    end
    // PC lower limit.
    s = idle(1'b0, rv); s.pc_we = 1; s.pc_in = 16'h0100; apply(s);
    s = idle(1'b0, rv); s.pc_we = 1; s.pc_in = 16'hC010; apply(s);
    apply(idle(1'b0, rv));
    // Port-A write with same-cycle read of the target.
    s = idle(1'b0, rv); s.we_a = 1; s.wa_addr = 7; s.wa_data = 16'h9999; s.da = 7; apply(s);
    s = idle(1'b0, rv); s.da = 7; apply(s);
    // Random traffic with occasional resets and new reset vectors.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        rv = 16'($urandom);
        apply(idle(1'b1, rv));
      end else begin
        apply(rnd(rv));
      end
    end
    @(negedge clk);
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", expq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_bank.md
REG_BANK -- requirements
Module: reg_bank

Interface
REQ-001 SHALL have parameter DATA_W, default 16, register width in bits (at least 16).
REQ-002 SHALL have parameter ADDR_W, default 4, register index width; register count NREG = 2**ADDR_W (at least 4).
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ports rst_vec  in  DATA_W  reset vector loaded into R0 (PC).
REQ-006 SHALL have ports sa, da  in  ADDR_W  source/destination read indices.
REQ-007 SHALL have port as  in  2  source addressing mode (constant-generator select).
REQ-008 SHALL have ports we_a, wa_addr, wa_data, bw_a  in  1/ADDR_W/DATA_W/1  primary (ALU result) write port; bw_a = byte write.
REQ-009 SHALL have ports we_b, wb_addr, wb_data  in  1/ADDR_W/DATA_W  secondary write port (auto-increment / SP adjust).
REQ-010 SHALL have ports pc_we, pc_in, sr_we, sr_in  in  1/DATA_W/1/DATA_W  dedicated PC and SR update ports.
REQ-011 SHALL have ports sout, dout, pc_out, sp_out, sr_out  out  DATA_W  read data; ready  out  1  bank initialised.

Function
REQ-012 SHALL implement a three-state FSM RESET -> CLEAR -> RUN; rst=1 forces RESET from any state, including mid-CLEAR.
REQ-013 SHALL leave RESET for CLEAR on the first cycle with rst=0; CLEAR SHALL write 0 to one register per cycle, index counter 0..NREG-1, then enter RUN; R0 SHALL receive rst_vec instead of 0.
REQ-014 SHALL drive ready=1 only in RUN; all write ports SHALL be ignored when ready=0.
REQ-015 SHALL provide combinational reads: sout=reg[sa], dout=reg[da], pc_out=R0, sp_out=R1, sr_out=R2.
REQ-016 SHALL override sout when sa=2 and as=01/10/11 with 0/4/8, and when sa=3 with 0/1/2/all-ones for as=00/01/10/11.
REQ-017 SHALL discard every write to R3.
REQ-018 SHALL, for bw_a=1, write wa_data[7:0] and clear bits DATA_W-1:8.
REQ-019 SHALL resolve same-cycle writes to one register with priority port A > port B > pc_we/sr_we; writes to different registers SHALL all take effect.
REQ-020 SHALL replace any R0 write value below 16'h0200 with rst_vec.
REQ-021 SHALL make written values visible on read outputs the cycle after the write (write latency 1).

Reset
REQ-022 SHALL, while rst=1, hold ready=0, load R0 with rst_vec and R2 with 0 each cycle; other registers hold until CLEAR.
REQ-023 SHALL present pc_out=rst_vec and sr_out=0 from the first cycle after rst is sampled high.

Configuration
REQ-024 SHALL support macro REG_BANK_BYPASS_EN: defined -> a read index matching wa_addr with we_a=1 and ready=1 returns the port-A write value (after byte masking) in the same cycle (constant-generator overrides still win); undefined -> reads return the stored value.

Structure
REQ-025 SHALL take from shared package reg_bank_pkg: register index constants (PC=0, SP=1, SR=2, CG=3), constant-generator values, PC lower limit 16'h0200, FSM state encoding.
REQ-026 SHALL isolate constant generation in sub-module reg_bank_cg (inputs as, sa, stored value; output sout).

Verification
REQ-027 rst 2 cycles, rst_vec=16'hF800 -> pc_out=F800 next cycle; ready=0 for NREG cycles after release, then 1; all other registers 0.
REQ-028 Assert rst at CLEAR index 5 -> FSM back to RESET, after release full NREG-cycle clear reruns.
REQ-029 we_a=we_b=1, both addr 4, wa=1234, wb=5678 -> reg4=1234; bw_a=1 wa_data=ABCD to R5 -> reg5=00CD.
REQ-030 sa=3 as=11 -> sout=FFFF; sa=2 as=10 -> sout=0004; write 1111 to R3 -> R3 still reads generator values.
REQ-031 pc_we=1 pc_in=0100 -> pc_out=rst_vec; pc_in=C010 -> pc_out=C010.
REQ-032 With REG_BANK_BYPASS_EN: we_a to R7 with 9999, da=7 -> dout=9999 same cycle; without: old value until next cycle.
